// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded lock in front of a single-port synchronous data memory.
// Read data returns one cycle after a granted read, tagged to the issuing port.
module dmem_arbiter #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } lock_state_t;

    lock_state_t   state, state_n;
    logic          prio, prio_n;
    logic          lock_own, lock_own_n;
    logic [CW-1:0] lock_cnt, lock_cnt_n;
    logic          rd_own, rd_own_n;
    logic          rd_pend, rd_pend_n;
    logic [AW-1:0] last_raddr, last_raddr_n;

    logic          hold, forced, fav;
    logic          gnt_any, gnt_port;
    logic          sel_we, sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Arbitration: a lock that can no longer hold falls through to the free rules,
    // with the owner demoted for this one arbitration once its count is exhausted.
    always_comb begin
        hold    = (state == ST_LOCKED) && (lock_own ? m1_req : m0_req) && (lock_cnt < CW'(MAX_LOCK));
        forced  = (state == ST_LOCKED) && (lock_cnt >= CW'(MAX_LOCK));
        fav     = forced ? ~lock_own : prio;
        gnt_any = m0_req | m1_req;
        if (hold)
            gnt_port = lock_own;
        else if (m0_req && m1_req)
            gnt_port = fav;
        else
            gnt_port = m1_req;

        sel_we    = gnt_port ? m1_we    : m0_we;
        sel_lock  = gnt_port ? m1_lock  : m0_lock;
        sel_addr  = gnt_port ? m1_addr  : m0_addr;
        sel_wdata = gnt_port ? m1_wdata : m0_wdata;
    end

    assign m0_gnt = gnt_any & ~gnt_port;
    assign m1_gnt = gnt_any &  gnt_port;

    // Idle cycles re-present the last read address so the memory output stays put.
    assign mem_we   = gnt_any & sel_we & rst_n;
    assign mem_addr = gnt_any ? sel_addr : last_raddr;
    assign mem_din  = sel_wdata;

    assign m0_rvalid = rd_pend & ~rd_own;
    assign m1_rvalid = rd_pend &  rd_own;
    assign m0_rdata  = mem_dout;
    assign m1_rdata  = mem_dout;

    always_comb begin
        state_n      = hold ? state : ST_FREE;
        lock_cnt_n   = hold ? lock_cnt : '0;
        lock_own_n   = lock_own;
        prio_n       = prio;
        rd_pend_n    = 1'b0;
        rd_own_n     = rd_own;
        last_raddr_n = last_raddr;
        if (gnt_any) begin
            prio_n = ~gnt_port;
            if (sel_lock) begin
                state_n    = ST_LOCKED;
                lock_own_n = gnt_port;
                lock_cnt_n = hold ? lock_cnt + CW'(1) : CW'(1);
            end else begin
                state_n    = ST_FREE;
                lock_cnt_n = '0;
            end
            if (!sel_we) begin
                rd_pend_n    = 1'b1;
                rd_own_n     = gnt_port;
                last_raddr_n = sel_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FREE;
            prio       <= 1'b0;
            lock_own   <= 1'b0;
            lock_cnt   <= '0;
            rd_own     <= 1'b0;
            rd_pend    <= 1'b0;
            last_raddr <= '0;
        end else begin
            state      <= state_n;
            prio       <= prio_n;
            lock_own   <= lock_own_n;
            lock_cnt   <= lock_cnt_n;
            rd_own     <= rd_own_n;
            rd_pend    <= rd_pend_n;
            last_raddr <= last_raddr_n;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model and a behavioural single-port memory.
module tb_dmem_arbiter;

    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, we = '0, lk = '0;
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_din, mem_dout;

    always #5 clk = ~clk;

    dmem_arbiter #(.DW(16), .AW(16), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lk[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lk[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'h1234;
        if (a == 16'h0030) return 16'h5555;
        return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
    endfunction

    // Single-port memory: address registered only on non-write cycles.
    bit [15:0] env_mem [65536];
    bit        env_wr  [65536];
    bit [15:0] env_ra;
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_din;
            env_wr[mem_addr]  <= 1'b1;
        end else begin
            env_ra <= mem_addr;
        end
    end
    assign mem_dout = env_wr[env_ra] ? env_mem[env_ra] : init_val(env_ra);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] ref_mem [65536];
    int          prio_m, lock_port, lock_run;
    bit          lock_on;
    bit [1:0]    rv_m, last_g;
    logic [15:0] rd_m, last_ra_m;
    logic [1:0]  obs_gnt, obs_rv;
    logic [15:0] obs_rd0, obs_rd1, obs_maddr;

    task automatic model_reset();
        prio_m = 0; lock_on = 0; lock_port = 0; lock_run = 0;
        rv_m = '0; last_g = '0; last_ra_m = '0;
    endtask

    // Called just after a falling edge with inputs already applied; returns after the next falling edge.
    task automatic run_cycle();
        int  g, fav;
        bit  hold;
        hold = lock_on && req[lock_port] && (lock_run < MAXL);
        if (hold) g = lock_port;
        else begin
            fav = (lock_on && lock_run >= MAXL) ? 1 - lock_port : prio_m;
            if (req[fav])          g = fav;
            else if (req[1 - fav]) g = 1 - fav;
            else                   g = -1;
        end
        #1;
        obs_gnt = {m1_gnt, m0_gnt}; obs_rv = {m1_rvalid, m0_rvalid};
        obs_rd0 = m0_rdata; obs_rd1 = m1_rdata; obs_maddr = mem_addr;
        check("gnt0", m0_gnt, g == 0);
        check("gnt1", m1_gnt, g == 1);
        check("rvalid0", m0_rvalid, rv_m[0]);
        check("rvalid1", m1_rvalid, rv_m[1]);
        if (rv_m[0]) check("rdata0", m0_rdata, rd_m);
        if (rv_m[1]) check("rdata1", m1_rdata, rd_m);
        if (g >= 0) begin
            check("mem_we", mem_we, we[g]);
            check("mem_addr", mem_addr, addr[g]);
            if (we[g]) check("mem_din", mem_din, wdata[g]);
        end else begin
            check("mem_we_idle", mem_we, 1'b0);
            check("mem_addr_idle", mem_addr, last_ra_m);
        end
        @(posedge clk);
        rv_m = '0;
        last_g = '0;
        if (!hold) begin lock_on = 0; lock_run = 0; end
        if (g >= 0) begin
            last_g[g] = 1'b1;
            prio_m = 1 - g;
            if (lk[g]) begin
                if (hold) lock_run++;
                else begin lock_on = 1; lock_port = g; lock_run = 1; end
            end else begin
                lock_on = 0; lock_run = 0;
            end
            if (we[g]) ref_mem[addr[g]] = wdata[g];
            else begin
                rv_m[g] = 1'b1; rd_m = ref_mem[addr[g]]; last_ra_m = addr[g];
            end
        end
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic l,
                            input logic [15:0] a, input logic [15:0] d);
        req[p] = r; we[p] = w; lk[p] = l; addr[p] = a; wdata[p] = d;
    endtask

    task automatic idle();
        req = '0; we = '0; lk = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] seq [10];

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
        model_reset();
        set_port(0, 1, 1, 0, 16'h0010, 16'h1111);
        set_port(1, 1, 1, 0, 16'h0020, 16'h2222);
        @(negedge clk);
        #1;
        check("rst_gnt0", m0_gnt, 1'b1);
        check("rst_gnt1", m1_gnt, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        idle();
        #1;
        check("rst_mem_addr", mem_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Uncontended read
        set_port(0, 1, 0, 0, 16'h0010, 16'h0);
        run_cycle();
        check("ur_gnt", obs_gnt, 2'b01);
        idle();
        run_cycle();
        check("ur_rv", obs_rv, 2'b01);
        check("ur_rdata", obs_rd0, 16'h1234);

        // Contention round-robin
        do_reset();
        set_port(0, 1, 0, 0, 16'h0010, 16'h0);
        set_port(1, 1, 0, 0, 16'h0030, 16'h0);
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            seq[i] = obs_gnt;
            if (i > 0) check("rr_rv", obs_rv, seq[i-1]);
        end
        check("rr_g0", seq[0], 2'b01);
        check("rr_g1", seq[1], 2'b10);
        check("rr_g2", seq[2], 2'b01);
        check("rr_g3", seq[3], 2'b10);
        idle();
        run_cycle();
        check("rr_rv_last", obs_rv, 2'b10);

        // Lock with forced release
        do_reset();
        set_port(0, 1, 0, 0, 16'h0010, 16'h0);
        set_port(1, 1, 0, 1, 16'h0030, 16'h0);
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            seq[i] = obs_gnt;
        end
        check("lk_first", seq[0], 2'b01);
        for (int i = 1; i <= 8; i++) check("lk_hold", seq[i], 2'b10);
        check("lk_release", seq[9], 2'b01);
        idle();
        run_cycle();

        // Write then read-back across ports
        set_port(0, 1, 1, 0, 16'h0020, 16'hBEEF);
        run_cycle();
        idle();
        set_port(1, 1, 0, 0, 16'h0020, 16'h0);
        run_cycle();
        idle();
        run_cycle();
        check("wr_rv", obs_rv, 2'b10);
        check("wr_rdata", obs_rd1, 16'hBEEF);

        // Read then write collision
        set_port(0, 1, 0, 0, 16'h0030, 16'h0);
        run_cycle();
        idle();
        set_port(1, 1, 1, 0, 16'h0040, 16'hAAAA);
        run_cycle();
        check("rw_rv", obs_rv, 2'b01);
        check("rw_rdata", obs_rd0, 16'h5555);
        idle();
        run_cycle();
        check("rw_idle_addr", obs_maddr, 16'h0030);
        run_cycle();

        // Mid-read reset
        set_port(0, 1, 0, 0, 16'h0010, 16'h0);
        run_cycle();
        idle();
        #1;
        check("mr_rv_before", m0_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_rv_after", {m1_rvalid, m0_rvalid}, 2'b00);
        check("mr_mem_we", mem_we, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_port(0, 1, 0, 0, 16'h0010, 16'h0);
        set_port(1, 1, 0, 0, 16'h0030, 16'h0);
        run_cycle();
        check("mr_first_gnt", obs_gnt, 2'b01);
        idle();
        run_cycle();

        // Random traffic; a losing port holds its transaction until granted
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && !last_g[p])) begin
                    req[p]   = ($urandom_range(0, 9) < 7);
                    we[p]    = ($urandom_range(0, 9) < 4);
                    lk[p]    = ($urandom_range(0, 9) < 4);
                    addr[p]  = 16'($urandom_range(0, 31));
                    wdata[p] = 16'($urandom);
                end
            end
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
